// File: rtl/core_csr_arb.sv
// CSR access sequencer/arbiter: serialises core and debug read-modify-write requests onto a
// single-port CSR file. Define CORE_CSR_ARB_DBG_EN to enable the debug requester.
module core_csr_arb #(
    parameter int CSR_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic [1:0]            core_req_op,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [CSR_WIDTH-1:0]  core_req_wdata,
    output logic                  core_rsp_valid,
    input  logic                  core_rsp_ready,
    output logic [CSR_WIDTH-1:0]  core_rsp_rdata,
    output logic                  core_rsp_err,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [1:0]            dbg_req_op,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [CSR_WIDTH-1:0]  dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [CSR_WIDTH-1:0]  dbg_rsp_rdata,
    output logic                  dbg_rsp_err,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic                  csr_re,
    input  logic [CSR_WIDTH-1:0]  csr_rdata,
    output logic                  csr_we,
    output logic [CSR_WIDTH-1:0]  csr_wdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    state_t                state, state_nxt;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CSR_WIDTH-1:0]  wdata_q;
    logic [CSR_WIDTH-1:0]  old_q;
    logic [CSR_WIDTH-1:0]  new_val;
    logic                  owner_q;     // 1 = debug owns the in-flight access
    logic                  err_q;
    logic                  core_gnt, dbg_gnt, accept;
    logic                  wr_needed, ro_hit, wr_en, rsp_ready_sel;

`ifdef CORE_CSR_ARB_DBG_EN
    localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] streak;

    assign dbg_gnt = dbg_req_valid && (!core_req_valid || streak == STREAK_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (accept) begin
            if (dbg_gnt || !dbg_req_valid)
                streak <= '0;
            else if (streak != 4'hF)
                streak <= streak + 4'd1;
        end
    end
`else
    logic unused_dbg;
    assign dbg_gnt    = 1'b0;
    assign unused_dbg = ^{dbg_req_valid, dbg_req_op, dbg_req_addr, dbg_req_wdata,
                          dbg_rsp_ready, 4'(STARVE_LIMIT)};
`endif

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign core_gnt       = core_req_valid && !dbg_gnt;
    assign accept         = (state == IDLE) && !rst && (core_gnt || dbg_gnt);
    assign core_req_ready = (state == IDLE) && !rst && core_gnt;
    assign dbg_req_ready  = (state == IDLE) && !rst && dbg_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            old_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            if (accept) begin
                owner_q <= dbg_gnt;
`ifdef CORE_CSR_ARB_DBG_EN
                op_q    <= op_t'(dbg_gnt ? dbg_req_op : core_req_op);
                addr_q  <= dbg_gnt ? dbg_req_addr : core_req_addr;
                wdata_q <= dbg_gnt ? dbg_req_wdata : core_req_wdata;
`else
                op_q    <= op_t'(core_req_op);
                addr_q  <= core_req_addr;
                wdata_q <= core_req_wdata;
`endif
            end
            if (state == WR) begin
                old_q <= csr_rdata;
                err_q <= ro_hit && wr_needed;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_needed = 1'b0;
        new_val   = csr_rdata;
        unique case (op_q)
            OP_WRITE: begin
                wr_needed = 1'b1;
                new_val   = wdata_q;
            end
            OP_SET: begin
                wr_needed = |wdata_q;
                new_val   = csr_rdata | wdata_q;
            end
            OP_CLEAR: begin
                wr_needed = |wdata_q;
                new_val   = csr_rdata & ~wdata_q;
            end
            default: ;
        endcase
    end

    // The top two address bits equal to 2'b11 mark the read-only CSR region.
    assign ro_hit        = addr_q[ADDR_WIDTH-1 -: 2] == 2'b11;
    assign wr_en         = (state == WR) && wr_needed && !ro_hit;
    assign rsp_ready_sel = owner_q ? dbg_rsp_ready : core_rsp_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RD;
            RD:      state_nxt = WR;
            WR:      state_nxt = RSP;
            RSP:     if (rsp_ready_sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign csr_addr  = addr_q;
    assign csr_re    = state == RD;
    assign csr_we    = wr_en;
    assign csr_wdata = wr_en ? new_val : '0;
    assign busy      = state != IDLE;

    assign core_rsp_valid = (state == RSP) && !owner_q;
    assign core_rsp_rdata = core_rsp_valid ? old_q : '0;
    assign core_rsp_err   = core_rsp_valid && err_q;

`ifdef CORE_CSR_ARB_DBG_EN
    assign dbg_rsp_valid = (state == RSP) && owner_q;
    assign dbg_rsp_rdata = dbg_rsp_valid ? old_q : '0;
    assign dbg_rsp_err   = dbg_rsp_valid && err_q;
`else
    assign dbg_rsp_valid = 1'b0;
    assign dbg_rsp_rdata = '0;
    assign dbg_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_core_csr_arb.sv
// Randomised scoreboard bench for core_csr_arb with a behavioural CSR file and reference model.
// Honours CORE_CSR_ARB_DBG_EN the same way the design does.
`timescale 1ns/1ps
module tb_core_csr_arb;
    localparam int CW    = 32;
    localparam int AW    = 12;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready, core_rsp_err;
    logic [1:0]    core_req_op;
    logic [AW-1:0] core_req_addr;
    logic [CW-1:0] core_req_wdata, core_rsp_rdata;
    logic          dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
    logic [1:0]    dbg_req_op;
    logic [AW-1:0] dbg_req_addr;
    logic [CW-1:0] dbg_req_wdata, dbg_rsp_rdata;
    logic [AW-1:0] csr_addr;
    logic          csr_re, csr_we, busy;
    logic [CW-1:0] csr_rdata = '0;
    logic [CW-1:0] csr_wdata;

    core_csr_arb #(.CSR_WIDTH(CW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_op(core_req_op), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_op(dbg_req_op), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
        .csr_addr(csr_addr), .csr_re(csr_re), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          owner;
        logic [AW-1:0] addr;
        logic [CW-1:0] old;
        logic [CW-1:0] newv;
        logic          we;
        logic          err;
    } xact_t;

    xact_t         exp_q[$];
    xact_t         cur;
    bit            grant_log[$];
    logic [CW-1:0] csr_mem [4096];
    logic [CW-1:0] ref_mem [4096];
    logic [AW-1:0] addr_tbl [8] = '{12'h340, 12'h341, 12'h300, 12'h7FF,
                                    12'hBFF, 12'hC00, 12'hC05, 12'hFFF};
    int            n_vec = 0, n_bad = 0;
    int            cyc = 0, t_acc = 0, m_run = 0, n_rsp = 0, n_we = 0;
    bit            outstanding = 1'b0;
    logic [CW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CSR file: read data one cycle after csr_re, noise otherwise.
    always @(posedge clk) begin
        if (csr_re) csr_rdata <= csr_mem[csr_addr];
        else        csr_rdata <= $urandom;
        if (csr_we) begin
            csr_mem[csr_addr] <= csr_wdata;
            n_we <= n_we + 1;
        end
    end

    task automatic set_csr(input logic [AW-1:0] a, input logic [CW-1:0] v);
        csr_mem[a] <= v;
        ref_mem[a] = v;
    endtask

    // Monitor: predicts grants and strobe timing, pushes expected responses, pops on handshake.
    always @(negedge clk) begin : monitor
        logic          dg, exp_cr, exp_dr, exp_re, exp_we, exp_cv, exp_dv, wr;
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [CW-1:0] wd;
        bit            was_idle;
        if (rst) begin
            if (outstanding) begin
                if (cur.we) ref_mem[cur.addr] = cur.old;
                exp_q.delete();
                outstanding = 1'b0;
            end
            m_run = 0;
            check("rst_core_req_ready", core_req_ready, 0);
            check("rst_dbg_req_ready", dbg_req_ready, 0);
            check("rst_core_rsp_valid", core_rsp_valid, 0);
            check("rst_dbg_rsp_valid", dbg_rsp_valid, 0);
            check("rst_csr_re", csr_re, 0);
            check("rst_csr_we", csr_we, 0);
            check("rst_busy", busy, 0);
            check("rst_csr_addr", csr_addr, 0);
            check("rst_core_rsp_rdata", core_rsp_rdata, 0);
        end else begin
            was_idle = !outstanding;
            dg = 1'b0;
            exp_cr = 1'b0;
            exp_dr = 1'b0;
            if (was_idle) begin
`ifdef CORE_CSR_ARB_DBG_EN
                dg = dbg_req_valid && (!core_req_valid || m_run == LIMIT);
`endif
                exp_dr = dg;
                exp_cr = core_req_valid && !dg;
            end
            check("core_req_ready", core_req_ready, exp_cr);
            check("dbg_req_ready", dbg_req_ready, exp_dr);
            check("busy", busy, outstanding);
            if (core_req_valid && core_req_ready) grant_log.push_back(1'b0);
            if (dbg_req_valid && dbg_req_ready) grant_log.push_back(1'b1);

            exp_re = outstanding && (cyc == t_acc + 1);
            exp_we = outstanding && (cyc == t_acc + 2) && cur.we;
            check("csr_re", csr_re, exp_re);
            check("csr_we", csr_we, exp_we);
            if (exp_re) check("csr_addr_rd", csr_addr, cur.addr);
            if (exp_we) begin
                check("csr_addr_wr", csr_addr, cur.addr);
                check("csr_wdata", csr_wdata, cur.newv);
            end

            exp_cv = outstanding && (cyc >= t_acc + 3) && !cur.owner;
            exp_dv = outstanding && (cyc >= t_acc + 3) && cur.owner;
            check("core_rsp_valid", core_rsp_valid, exp_cv);
            check("dbg_rsp_valid", dbg_rsp_valid, exp_dv);
            if (core_rsp_valid || dbg_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: response with empty scoreboard at %0t", $time);
                end else if (core_rsp_valid) begin
                    check("core_rsp_rdata", core_rsp_rdata, exp_q[0].old);
                    check("core_rsp_err", core_rsp_err, exp_q[0].err);
                end else begin
                    check("dbg_rsp_rdata", dbg_rsp_rdata, exp_q[0].old);
                    check("dbg_rsp_err", dbg_rsp_err, exp_q[0].err);
                end
            end
`ifndef CORE_CSR_ARB_DBG_EN
            check("dbg_rsp_rdata_tied", dbg_rsp_rdata, 0);
            check("dbg_rsp_err_tied", dbg_rsp_err, 0);
`endif
            if ((exp_cv && core_rsp_ready) || (exp_dv && dbg_rsp_ready)) begin
                last_rdata = exp_cv ? core_rsp_rdata : dbg_rsp_rdata;
                last_err   = exp_cv ? core_rsp_err : dbg_rsp_err;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                outstanding = 1'b0;
                n_rsp++;
            end

            if (was_idle && (exp_cr || exp_dr)) begin
                op = dg ? dbg_req_op : core_req_op;
                a  = dg ? dbg_req_addr : core_req_addr;
                wd = dg ? dbg_req_wdata : core_req_wdata;
                cur.owner = dg;
                cur.addr  = a;
                cur.old   = ref_mem[a];
                wr        = (op == 2'b01) || (op[1] && wd != 0);
                cur.err   = wr && (a[11:10] == 2'b11);
                cur.we    = wr && !cur.err;
                case (op)
                    2'b01:   cur.newv = wd;
                    2'b10:   cur.newv = cur.old | wd;
                    2'b11:   cur.newv = cur.old & ~wd;
                    default: cur.newv = cur.old;
                endcase
                if (cur.we) ref_mem[a] = cur.newv;
                exp_q.push_back(cur);
                outstanding = 1'b1;
                t_acc = cyc;
                if (dg || !dbg_req_valid) m_run = 0;
                else if (m_run < 15)      m_run = m_run + 1;
            end
        end
    end

    task automatic core_xact(input logic [1:0] op, input logic [AW-1:0] a,
                             input logic [CW-1:0] wd, input int hold);
        int n0;
        bit ok;
        n0 = n_rsp;
        @(posedge clk); #1;
        core_req_valid = 1'b1;
        core_req_op    = op;
        core_req_addr  = a;
        core_req_wdata = wd;
        core_rsp_ready = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = core_req_ready;
        end
        check("core_accept", ok, 1);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        if (hold > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                ok = core_rsp_valid;
            end
            repeat (hold) @(posedge clk);
            #1 core_rsp_ready = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (n_rsp != n0);
        end
        check("core_rsp_done", ok, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  w0, n0;
        bit  ok;
        core_req_valid = 1'b1;
        dbg_req_valid  = 1'b1;
        core_req_op = 2'b01; core_req_addr = '0; core_req_wdata = '0;
        dbg_req_op  = 2'b01; dbg_req_addr  = '0; dbg_req_wdata  = '0;
        core_rsp_ready = 1'b0;
        dbg_rsp_ready  = 1'b0;
        for (int i = 0; i < 4096; i++) set_csr(AW'(i), '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;

        set_csr(12'h340, 32'h1);
        w0 = n_we;
        core_xact(2'b01, 12'h340, 32'hDEADBEEF, 0);
        check("wr_rdata", last_rdata, 32'h1);
        check("wr_err", last_err, 0);
        check("wr_we_count", n_we - w0, 1);
        check("wr_csr", csr_mem[12'h340], 32'hDEADBEEF);

        set_csr(12'h300, 32'h00F0);
        core_xact(2'b10, 12'h300, 32'h000F, 0);
        check("set_rdata", last_rdata, 32'h00F0);
        check("set_csr", csr_mem[12'h300], 32'h00FF);
        core_xact(2'b11, 12'h300, 32'h00F0, 0);
        check("clr_rdata", last_rdata, 32'h00FF);
        check("clr_csr", csr_mem[12'h300], 32'h000F);
        w0 = n_we;
        core_xact(2'b10, 12'h300, 32'h0, 0);
        check("set0_no_we", n_we - w0, 0);
        check("set0_rdata", last_rdata, 32'h000F);

        set_csr(12'hC00, 32'h5555AAAA);
        w0 = n_we;
        core_xact(2'b01, 12'hC00, 32'h1234, 0);
        check("ro_err", last_err, 1);
        check("ro_rdata", last_rdata, 32'h5555AAAA);
        check("ro_no_we", n_we - w0, 0);
        check("ro_csr", csr_mem[12'hC00], 32'h5555AAAA);
        core_xact(2'b00, 12'hC00, 32'h0, 0);
        check("ro_read_err", last_err, 0);

        core_xact(2'b01, 12'h341, 32'hCAFEF00D, 10);
        check("bp_rdata", last_rdata, 32'h0);

        // Reset while the write strobe is up: write dropped, no response.
        set_csr(12'h342, 32'h12345678);
        w0 = n_we;
        n0 = n_rsp;
        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_op = 2'b01;
        core_req_addr = 12'h342; core_req_wdata = 32'hAAAA5555;
        core_rsp_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = core_req_ready;
        end
        @(posedge clk); #1 core_req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = csr_we;
        end
        check("rst_saw_we", ok, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_we_async", csr_we, 0);
        check("rst_busy_async", busy, 0);
        check("rst_rsp_async", core_rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        core_rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        check("rst_no_write", csr_mem[12'h342], 32'h12345678);
        check("rst_no_we", n_we - w0, 0);
        check("rst_no_rsp", n_rsp - n0, 0);

`ifdef CORE_CSR_ARB_DBG_EN
        grant_log.delete();
        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_op = 2'b00; core_req_addr = 12'h300;
        dbg_req_valid  = 1'b1; dbg_req_op  = 2'b00; dbg_req_addr  = 12'h340;
        core_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1;
        for (int i = 0; i < 200 && grant_log.size() < 10; i++) @(negedge clk);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        check("starve_grants", grant_log.size() >= 10, 1);
        for (int k = 0; k < 10; k++)
            if (k < grant_log.size())
                check($sformatf("starve_grant%0d", k), grant_log[k], (k % 5) == 4);
        repeat (6) @(posedge clk);
`else
        @(posedge clk); #1 dbg_req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("dbg_ready_tied", dbg_req_ready, 0);
        end
        @(posedge clk); #1 dbg_req_valid = 1'b0;
`endif

        for (int i = 0; i < 8; i++) set_csr(addr_tbl[i], $urandom);
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            core_req_valid = ($urandom_range(0, 2) != 0);
            core_req_op    = 2'($urandom);
            core_req_addr  = addr_tbl[$urandom_range(0, 7)];
            core_req_wdata = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            dbg_req_valid  = ($urandom_range(0, 1) != 0);
            dbg_req_op     = 2'($urandom);
            dbg_req_addr   = addr_tbl[$urandom_range(0, 7)];
            dbg_req_wdata  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            core_rsp_ready = ($urandom_range(0, 3) != 0);
            dbg_rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        core_rsp_ready = 1'b1;
        dbg_rsp_ready  = 1'b1;
        for (int i = 0; i < 20 && outstanding; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        check("drain_idle", outstanding, 0);
        check("sb_empty", exp_q.size(), 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("final_csr_%03h", addr_tbl[i]), csr_mem[addr_tbl[i]], ref_mem[addr_tbl[i]]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
